pedestrian_signal: RTL and testbench



---
 rtl/intersection_pkg.sv | 29 ++
 rtl/pedestrian_signal_if.sv | 33 +++
 rtl/pedestrian_signal_button_debounce.sv | 68 ++++++
 rtl/pedestrian_signal.sv | 134 +++++++++++++
 tb/tb_pedestrian_signal.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/intersection_pkg.sv
// Shared intersection definitions: pedestrian FSM encodings, lamp masks,
// default timing constants and the red-valid decode.
package intersection_pkg;

  typedef enum logic [1:0] {
    PED_IDLE  = 2'd0,
    PED_WAIT  = 2'd1,
    PED_WALK  = 2'd2,
    PED_FLASH = 2'd3
  } ped_state_t;

  // Lamp masks as {red, yellow, green}; ERR is the controller's fault mask.
  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YLW = 3'b010;
  localparam logic [2:0] GRN = 3'b001;
  localparam logic [2:0] ERR = 3'b111;

  localparam int unsigned DEF_DEBOUNCE   = 4;
  localparam int unsigned DEF_RED_SETTLE = 2;
  localparam int unsigned DEF_WALK_TON   = 16;
  localparam int unsigned DEF_FLASH_TON  = 8;
  localparam int unsigned DEF_FLASH_HALF = 2;

  // Only a clean red-alone pattern counts as red; all-off and multi-hot do not.
  function automatic logic lamps_red_ok(input logic [2:0] lamps);
    return lamps == RED;
  endfunction

endpackage

// File: rtl/pedestrian_signal_if.sv
// Pedestrian endpoint signal bundle: button and traffic lamps in,
// crossing request and pedestrian lamps out.
interface pedestrian_signal_if;

  logic cross_button;
  logic red_trffc_light;
  logic ylw_trffc_light;
  logic grn_trffc_light;
  logic cross_rqst;
  logic walk_light;
  logic stop_light;

  modport slave (
    input  cross_button,
    input  red_trffc_light,
    input  ylw_trffc_light,
    input  grn_trffc_light,
    output cross_rqst,
    output walk_light,
    output stop_light
  );

  modport master (
    output cross_button,
    output red_trffc_light,
    output ylw_trffc_light,
    output grn_trffc_light,
    input  cross_rqst,
    input  walk_light,
    input  stop_light
  );

endinterface

// File: rtl/pedestrian_signal_button_debounce.sv
// Crosswalk button conditioning: 2-flop synchronizer plus debounce counter.
// Emits one press_accept pulse per press; re-arms after DEBOUNCE high samples.
module button_debounce
  import intersection_pkg::*;
#(
  parameter int unsigned DEBOUNCE = DEF_DEBOUNCE
) (
  input  logic clk,
  input  logic reset_n,
  input  logic cross_button,
  output logic press_accept
);

  localparam logic [7:0] LAST = 8'(DEBOUNCE - 1);

  logic       sync_a;
  logic       sync_b;
  logic [7:0] cnt;
  logic       armed;

  // Synchronize the raw active-low button; released (high) out of reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_a <= 1'b1;
      sync_b <= 1'b1;
    end else begin
      sync_a <= cross_button;
      sync_b <= sync_a;
    end
  end

  // One counter serves both directions: while armed it counts low samples
  // toward an accept, while disarmed it counts high samples toward re-arm.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt          <= '0;
      armed        <= 1'b1;
      press_accept <= 1'b0;
    end else begin
      press_accept <= 1'b0;
      if (armed) begin
        if (!sync_b) begin
          if (cnt == LAST) begin
            press_accept <= 1'b1;
            armed        <= 1'b0;
            cnt          <= '0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end else begin
          cnt <= '0;
        end
      end else begin
        if (sync_b) begin
          if (cnt == LAST) begin
            armed <= 1'b1;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end else begin
          cnt <= '0;
        end
      end
    end
  end

endmodule

// File: rtl/pedestrian_signal.sv
// Pedestrian-side endpoint for one approach: latches a debounced crossing
// request and sequences WALK / flashing STOP while the vehicle light is red.
module pedestrian_signal
  import intersection_pkg::*;
#(
  parameter int unsigned DEBOUNCE   = DEF_DEBOUNCE,
  parameter int unsigned RED_SETTLE = DEF_RED_SETTLE,
  parameter int unsigned WALK_TON   = DEF_WALK_TON,
  parameter int unsigned FLASH_TON  = DEF_FLASH_TON,
  parameter int unsigned FLASH_HALF = DEF_FLASH_HALF
) (
  input  logic                clk,
  input  logic                reset_n,
  pedestrian_signal_if.slave  bus
);

  localparam logic [7:0] SETTLE     = 8'(RED_SETTLE);
  localparam logic [7:0] WALK_LAST  = 8'(WALK_TON - 1);
  localparam logic [7:0] FLASH_LAST = 8'(FLASH_TON - 1);
  localparam logic [7:0] HALF_LAST  = 8'(FLASH_HALF - 1);

  ped_state_t state;
  logic [7:0] phase;
  logic [7:0] half_cnt;
  logic [7:0] red_cnt;
  logic       press_accept;
  logic       red_ok;
  logic       red_settled;
  logic       rqst_q;
  logic       walk_q;
  logic       stop_q;

  button_debounce #(
    .DEBOUNCE(DEBOUNCE)
  ) u_debounce (
    .clk          (clk),
    .reset_n      (reset_n),
    .cross_button (bus.cross_button),
    .press_accept (press_accept)
  );

  assign red_ok      = lamps_red_ok({bus.red_trffc_light, bus.ylw_trffc_light, bus.grn_trffc_light});
  assign red_settled = (red_cnt >= SETTLE);

  assign bus.cross_rqst = rqst_q;
  assign bus.walk_light = walk_q;
  assign bus.stop_light = stop_q;

  // Count consecutive valid-red cycles, saturating; any non-red clears it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      red_cnt <= '0;
    end else if (!red_ok) begin
      red_cnt <= '0;
    end else if (red_cnt != 8'hFF) begin
      red_cnt <= red_cnt + 8'd1;
    end
  end

  // Crossing sequencer with registered lamps and request latch.
  // Requests are only latched from IDLE, which absorbs presses during
  // WAIT/WALK/FLASH (including one coinciding with FLASH entry).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= PED_IDLE;
      phase    <= '0;
      half_cnt <= '0;
      rqst_q   <= 1'b0;
      walk_q   <= 1'b0;
      stop_q   <= 1'b1;
    end else begin
      case (state)
        PED_IDLE: begin
          if (press_accept && !rqst_q) begin
            rqst_q <= 1'b1;
          end
          if (rqst_q) begin
            state <= PED_WAIT;
            phase <= '0;
          end
        end
        PED_WAIT: begin
          if (red_ok && red_settled) begin
            state  <= PED_WALK;
            phase  <= WALK_LAST;
            walk_q <= 1'b1;
            stop_q <= 1'b0;
          end
        end
        PED_WALK: begin
          if (!red_ok) begin
            state  <= PED_WAIT;
            phase  <= '0;
            rqst_q <= 1'b1;
            walk_q <= 1'b0;
            stop_q <= 1'b1;
          end else if (phase == '0) begin
            state    <= PED_FLASH;
            phase    <= FLASH_LAST;
            half_cnt <= HALF_LAST;
            rqst_q   <= 1'b0;
            walk_q   <= 1'b0;
            stop_q   <= 1'b1;
          end else begin
            phase <= phase - 8'd1;
          end
        end
        PED_FLASH: begin
          if (!red_ok || phase == '0) begin
            state  <= PED_IDLE;
            phase  <= '0;
            walk_q <= 1'b0;
            stop_q <= 1'b1;
          end else begin
            phase <= phase - 8'd1;
            if (half_cnt == '0) begin
              stop_q   <= ~stop_q;
              half_cnt <= HALF_LAST;
            end else begin
              half_cnt <= half_cnt - 8'd1;
            end
          end
        end
        default: begin
          state  <= PED_IDLE;
          phase  <= '0;
          walk_q <= 1'b0;
          stop_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pedestrian_signal.sv
// Directed bench for pedestrian_signal: a vector table for bounce and a
// normal crossing, then hand sequences for abort, invalid lamps, held
// button and asynchronous reset.
module tb_pedestrian_signal;
  import intersection_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  pedestrian_signal_if bus ();

  pedestrian_signal #(
    .DEBOUNCE   (4),
    .RED_SETTLE (2),
    .WALK_TON   (16),
    .FLASH_TON  (8),
    .FLASH_HALF (2)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic       btn;
    logic [2:0] lamps;
    logic       rqst;
    logic       walk;
    logic       stop;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input int n, input logic btn, input logic [2:0] lamps,
                              input logic rq, input logic wk, input logic st);
    vec_t v;
    v.btn = btn; v.lamps = lamps; v.rqst = rq; v.walk = wk; v.stop = st;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic btn, input logic [2:0] l);
    bus.cross_button    = btn;
    bus.red_trffc_light = l[2];
    bus.ylw_trffc_light = l[1];
    bus.grn_trffc_light = l[0];
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0:       return bus.cross_rqst;
      1:       return bus.walk_light;
      2:       return bus.stop_light;
      default: return dut.state == PED_IDLE;
    endcase
  endfunction

  task automatic wait_sig(input int sel, input logic val, input int max, input string nm);
    int n = 0;
    while (sig(sel) !== val && n < max) begin
      step();
      n++;
    end
    checks++;
    if (sig(sel) !== val) begin
      failures++;
      $display("FAIL %s timeout actual=%0b expected=%0b", nm, sig(sel), val);
    end
  endtask

  task automatic press(input logic [2:0] l);
    drive(1'b0, l);
    repeat (4) step();
    drive(1'b1, l);
  endtask

  initial begin
    int wc;
    int rq_rise;
    int wk_rise;
    logic prev_rq;
    logic prev_wk;

    // Bounce: 3 raw lows then quiet; nothing may happen.
    add(3, 1'b0, GRN, 1'b0, 1'b0, 1'b1);
    add(8, 1'b1, GRN, 1'b0, 1'b0, 1'b1);
    // Press of 4 raw lows: request at edge 6 after the first low sample.
    add(4, 1'b0, GRN, 1'b0, 1'b0, 1'b1);
    add(2, 1'b1, GRN, 1'b0, 1'b0, 1'b1);
    add(3, 1'b1, GRN, 1'b1, 1'b0, 1'b1);
    // Red settles over two cycles, then 16 WALK cycles.
    add(2, 1'b1, RED, 1'b1, 1'b0, 1'b1);
    add(16, 1'b1, RED, 1'b1, 1'b1, 1'b0);
    // Flash 1,1,0,0,1,1,0,0 with the request cleared, then IDLE.
    add(2, 1'b1, RED, 1'b0, 1'b0, 1'b1);
    add(2, 1'b1, RED, 1'b0, 1'b0, 1'b0);
    add(2, 1'b1, RED, 1'b0, 1'b0, 1'b1);
    add(2, 1'b1, RED, 1'b0, 1'b0, 1'b0);
    add(2, 1'b1, RED, 1'b0, 1'b0, 1'b1);

    reset_n = 1'b0;
    drive(1'b1, GRN);
    repeat (3) step();
    check("reset rqst", 32'(bus.cross_rqst), 32'd0);
    check("reset walk", 32'(bus.walk_light), 32'd0);
    check("reset stop", 32'(bus.stop_light), 32'd1);
    reset_n = 1'b1;
    step();
    check("post reset state", 32'(dut.state), 32'(PED_IDLE));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].btn, vecs[i].lamps);
      step();
      check($sformatf("vec%0d rqst", i), 32'(bus.cross_rqst), 32'(vecs[i].rqst));
      check($sformatf("vec%0d walk", i), 32'(bus.walk_light), 32'(vecs[i].walk));
      check($sformatf("vec%0d stop", i), 32'(bus.stop_light), 32'(vecs[i].stop));
    end
    check("table end state", 32'(dut.state), 32'(PED_IDLE));

    // Safety abort at WALK cycle 5, then a full re-served WALK.
    press(RED);
    wait_sig(1, 1'b1, 20, "abort walk start");
    repeat (4) step();
    check("abort pre walk", 32'(bus.walk_light), 32'd1);
    drive(1'b1, YLW);
    step();
    check("abort walk", 32'(bus.walk_light), 32'd0);
    check("abort stop", 32'(bus.stop_light), 32'd1);
    check("abort rqst", 32'(bus.cross_rqst), 32'd1);
    check("abort state", 32'(dut.state), 32'(PED_WAIT));
    drive(1'b1, RED);
    wait_sig(1, 1'b1, 10, "abort rewalk start");
    wc = 0;
    while (bus.walk_light === 1'b1 && wc < 40) begin
      wc++;
      step();
    end
    check("abort rewalk len", 32'(wc), 32'd16);
    check("abort flash state", 32'(dut.state), 32'(PED_FLASH));
    check("abort flash rqst", 32'(bus.cross_rqst), 32'd0);
    wait_sig(3, 1'b1, 20, "abort back to idle");

    // Invalid lamp patterns hold WAIT with STOP steady.
    press(RED | GRN);
    wait_sig(0, 1'b1, 20, "invalid rqst");
    for (int i = 0; i < 24; i++) begin
      drive(1'b1, (i < 12) ? (RED | GRN) : ERR);
      step();
      check($sformatf("invalid lamps %0d", i),
            32'({bus.walk_light, bus.stop_light}), 32'b01);
    end
    check("invalid state", 32'(dut.state), 32'(PED_WAIT));
    drive(1'b1, RED);
    wait_sig(1, 1'b1, 10, "invalid then walk");
    wait_sig(3, 1'b1, 40, "invalid back to idle");

    // Held button: exactly one request and one WALK over 200 cycles.
    drive(1'b0, RED);
    rq_rise = 0;
    wk_rise = 0;
    prev_rq = bus.cross_rqst;
    prev_wk = bus.walk_light;
    for (int i = 0; i < 200; i++) begin
      step();
      if (bus.cross_rqst && !prev_rq) rq_rise++;
      if (bus.walk_light && !prev_wk) wk_rise++;
      prev_rq = bus.cross_rqst;
      prev_wk = bus.walk_light;
    end
    check("held rqst count", 32'(rq_rise), 32'd1);
    check("held walk count", 32'(wk_rise), 32'd1);
    check("held rqst end", 32'(bus.cross_rqst), 32'd0);
    drive(1'b1, RED);
    repeat (4) step();
    press(RED);
    wait_sig(0, 1'b1, 10, "repress rqst");
    wait_sig(3, 1'b1, 60, "repress back to idle");

    // Asynchronous reset mid-WALK.
    press(RED);
    wait_sig(1, 1'b1, 20, "reset walk start");
    repeat (3) step();
    #2;
    reset_n = 1'b0;
    #1;
    check("async reset walk", 32'(bus.walk_light), 32'd0);
    check("async reset stop", 32'(bus.stop_light), 32'd1);
    check("async reset rqst", 32'(bus.cross_rqst), 32'd0);
    repeat (2) step();
    reset_n = 1'b1;
    step();
    check("async reset state", 32'(dut.state), 32'(PED_IDLE));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
